// File: rtl/calc_core_if.sv
// Operator panel and display bundle for calc_core: switches, keys and op buttons in; magnitude, display code, busy and done out.
// The master drives the panel inputs; the slave (calc_core) drives the display-side outputs.
interface calc_core_if;
  logic [3:0]  sw;
  logic [1:0]  keys;
  logic [3:0]  arifs;
  logic [10:0] ind_from_ALU;
  logic [2:0]  c_from_ALU;
  logic        busy;
  logic        done;

  modport master (output sw, keys, arifs, input ind_from_ALU, c_from_ALU, busy, done);
  modport slave  (input sw, keys, arifs, output ind_from_ALU, c_from_ALU, busy, done);
endinterface

// File: rtl/calc_core.sv
// Two-digit calculator core: add/sub/mul resolve one cycle after execute, div takes 14 extra busy cycles.
// No backpressure: presses during EXEC/DIV are dropped, and results hold in DONE until the next press.
module calc_core #(
  parameter int DISP_MAX = 1999
) (
  input  logic Clk,
  input  logic Rst,
  calc_core_if.slave bus
);
  typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, DIV, DONE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  localparam logic [13:0] LIMIT = 14'(DISP_MAX);

  state_t      r_state, w_next;
  op_t         r_op, w_op_dec;
  logic [1:0]  r_keys_d1, r_keys_d2;
  logic [6:0]  r_a, r_b;
  logic [1:0]  r_cnt_a, r_cnt_b;
  logic [10:0] r_ind;
  logic [2:0]  r_code;
  logic        r_done;
  logic [13:0] r_dvd;
  logic [6:0]  r_rem;
  logic [3:0]  r_dcnt;

  logic [1:0]  w_press;
  logic        w_exe, w_dig_ok, w_op_ok, w_ge, w_exact;
  logic [13:0] w_prod, w_q_nx, w_q100;
  logic [7:0]  w_trial;
  logic [6:0]  w_rem_nx;

  // keys[1] wins a simultaneous press; keys[0] only counts with a valid decimal digit
  assign w_press  = r_keys_d1 & ~r_keys_d2;
  assign w_exe    = w_press[1];
  assign w_dig_ok = w_press[0] & ~w_press[1] & (bus.sw <= 4'd9);
  assign w_prod   = {7'd0, r_a} * {7'd0, r_b};

  always_comb begin
    w_op_dec = OP_NONE;
    case (bus.arifs)
      4'b1110: w_op_dec = OP_ADD;
      4'b1101: w_op_dec = OP_SUB;
      4'b1011: w_op_dec = OP_MUL;
      4'b0111: w_op_dec = OP_DIV;
      default: w_op_dec = OP_NONE;
    endcase
  end
  assign w_op_ok = (w_op_dec != OP_NONE);

  // Remainder stays below B (<=99), so 7 bits plus the shifted-in dividend bit suffice
  assign w_trial  = {r_rem, r_dvd[13]};
  assign w_ge     = (w_trial >= {1'b0, r_b});
  assign w_rem_nx = w_ge ? 7'(w_trial - {1'b0, r_b}) : w_trial[6:0];
  assign w_q_nx   = {r_dvd[12:0], w_ge};
  assign w_q100   = w_q_nx / 14'd100;
  // With B<=99 a non-integer A/B has a fraction >=1/99, so an exact A/B is equivalent to Q being a multiple of 100
  assign w_exact  = ((w_q100 * 14'd100) == w_q_nx);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ENTER_A;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    bus.busy         = (r_state == DIV);
    bus.done         = r_done;
    bus.ind_from_ALU = r_ind;
    bus.c_from_ALU   = r_code;
    unique case (r_state)
      ENTER_A: begin
        bus.ind_from_ALU = {4'd0, r_a};
        bus.c_from_ALU   = 3'd0;
        if (w_exe && w_op_ok) w_next = ENTER_B;
      end
      ENTER_B: begin
        bus.ind_from_ALU = {4'd0, r_b};
        bus.c_from_ALU   = 3'd0;
        if (w_exe) w_next = EXEC;
      end
      EXEC:    w_next = (r_op == OP_DIV && r_b != 7'd0) ? DIV : DONE;
      DIV:     if (r_dcnt == 4'd13) w_next = DONE;
      DONE:    if (w_exe || w_dig_ok) w_next = ENTER_A;
      default: w_next = ENTER_A;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_keys_d1 <= 2'd0;
      r_keys_d2 <= 2'd0;
      r_a       <= 7'd0;
      r_b       <= 7'd0;
      r_cnt_a   <= 2'd0;
      r_cnt_b   <= 2'd0;
      r_op      <= OP_NONE;
      r_ind     <= 11'd0;
      r_code    <= 3'd0;
      r_done    <= 1'b0;
      r_dvd     <= 14'd0;
      r_rem     <= 7'd0;
      r_dcnt    <= 4'd0;
    end else begin
      r_keys_d1 <= bus.keys;
      r_keys_d2 <= r_keys_d1;
      r_done    <= (w_next == DONE) && (r_state != DONE);
      unique case (r_state)
        ENTER_A: begin
          if (w_exe) begin
            if (w_op_ok) begin
              r_op    <= w_op_dec;
              r_b     <= 7'd0;
              r_cnt_b <= 2'd0;
            end
          end else if (w_dig_ok && r_cnt_a < 2'd2) begin
            r_a     <= r_a * 7'd10 + {3'd0, bus.sw};
            r_cnt_a <= r_cnt_a + 2'd1;
          end
        end
        ENTER_B: begin
          if (!w_exe && w_dig_ok && r_cnt_b < 2'd2) begin
            r_b     <= r_b * 7'd10 + {3'd0, bus.sw};
            r_cnt_b <= r_cnt_b + 2'd1;
          end
        end
        EXEC: begin
          unique case (r_op)
            OP_ADD: begin
              r_ind  <= {3'd0, {1'b0, r_a} + {1'b0, r_b}};
              r_code <= 3'd0;
            end
            OP_SUB: begin
              r_ind  <= (r_a >= r_b) ? {4'd0, r_a - r_b} : {4'd0, r_b - r_a};
              r_code <= (r_a >= r_b) ? 3'd0 : 3'd1;
            end
            OP_MUL: begin
              r_ind  <= (w_prod <= LIMIT) ? w_prod[10:0] : 11'd0;
              r_code <= (w_prod <= LIMIT) ? 3'd0 : 3'd2;
            end
            OP_DIV: begin
              if (r_b == 7'd0) begin
                r_ind  <= 11'd0;
                r_code <= 3'd2;
              end else begin
                r_dvd  <= {7'd0, r_a} * 14'd100;
                r_rem  <= 7'd0;
                r_dcnt <= 4'd0;
              end
            end
            default: begin
              r_ind  <= 11'd0;
              r_code <= 3'd2;
            end
          endcase
        end
        DIV: begin
          r_dvd  <= w_q_nx;
          r_rem  <= w_rem_nx;
          r_dcnt <= r_dcnt + 4'd1;
          if (r_dcnt == 4'd13) begin
            if (w_exact) begin
              r_ind  <= w_q100[10:0];
              r_code <= 3'd0;
            end else if (w_q_nx <= LIMIT) begin
              r_ind  <= w_q_nx[10:0];
              r_code <= 3'd4;
            end else begin
              r_ind  <= w_q100[10:0];
              r_code <= 3'd0;
            end
          end
        end
        DONE: begin
          if (w_exe) begin
            r_a     <= 7'd0;
            r_b     <= 7'd0;
            r_cnt_a <= 2'd0;
            r_cnt_b <= 2'd0;
            r_op    <= OP_NONE;
            r_ind   <= 11'd0;
            r_code  <= 3'd0;
          end else if (w_dig_ok) begin
            r_a     <= {3'd0, bus.sw};
            r_b     <= 7'd0;
            r_cnt_a <= 2'd1;
            r_cnt_b <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: directed vector table, hand-written corner sequences and random operations against a reference model.
module tb_calc_core;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  calc_core_if bus();
  calc_core #(.DISP_MAX(1999)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  localparam logic [3:0] ADD = 4'b1110, SUB = 4'b1101, MUL = 4'b1011, DVD = 4'b0111;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         a;
    int         b;
    logic [3:0] op;
    int         ind;   // -1: magnitude not checked
    int         code;
    int         busy;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [1:0] k, input int d);
    @(negedge Clk);
    bus.keys = k;
    bus.sw   = 4'(d);
    @(negedge Clk);
    bus.keys = 2'b00;
    @(negedge Clk);
  endtask

  task automatic enter_num(input int v);
    if (v >= 10) press(2'b01, v / 10);
    press(2'b01, v % 10);
  endtask

  task automatic set_op(input logic [3:0] code);
    bus.arifs = code;
    press(2'b10, 0);
    bus.arifs = 4'b1111;
  endtask

  // Watch a fixed window after execute; optionally poke keys while a division runs
  task automatic observe(input bit poke, output int ind, output int code, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      busy_n += int'(bus.busy);
      done_n += int'(bus.done);
      if (poke && i == 3) bus.keys = 2'b01;
      if (poke && i == 5) bus.keys = 2'b10;
      if (poke && i == 7) bus.keys = 2'b00;
    end
    ind  = int'(bus.ind_from_ALU);
    code = int'(bus.c_from_ALU);
  endtask

  task automatic do_calc(input string name, input vec_t v, input bit poke);
    int ind, code, busy_n, done_n;
    enter_num(v.a);
    check($sformatf("%s showA", name), int'(bus.ind_from_ALU), v.a);
    set_op(v.op);
    enter_num(v.b);
    check($sformatf("%s showB", name), int'(bus.ind_from_ALU), v.b);
    press(2'b10, 0);
    observe(poke, ind, code, busy_n, done_n);
    if (v.ind >= 0) check($sformatf("%s ind", name), ind, v.ind);
    check($sformatf("%s code", name), code, v.code);
    check($sformatf("%s busy", name), busy_n, v.busy);
    check($sformatf("%s done", name), done_n, 1);
    press(2'b10, 0);
  endtask

  function automatic vec_t model(input int a, input int b, input logic [3:0] op);
    vec_t r;
    int q;
    r.a = a; r.b = b; r.op = op; r.busy = 0; r.code = 0; r.ind = 0;
    case (op)
      ADD: r.ind = a + b;
      SUB: begin r.ind = (a >= b) ? a - b : b - a; r.code = (a >= b) ? 0 : 1; end
      MUL: if (a * b <= 1999) r.ind = a * b; else r.code = 2;
      default: begin
        if (b == 0) begin r.ind = -1; r.code = 2; end
        else begin
          r.busy = 14;
          q = (a * 100) / b;
          if (a % b == 0)   r.ind = a / b;
          else if (q <= 1999) begin r.ind = q; r.code = 4; end
          else               r.ind = q / 100;
        end
      end
    endcase
    return r;
  endfunction

  task automatic do_reset();
    bus.keys = 2'b00; bus.sw = 4'd0; bus.arifs = 4'b1111;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int ind, code, busy_n, done_n, cnt;
    logic [3:0] ops[4];
    vec_t v;
    ops[0] = ADD; ops[1] = SUB; ops[2] = MUL; ops[3] = DVD;
    tbl[0]  = '{42, 35, ADD,   77, 0, 0};
    tbl[1]  = '{99, 99, ADD,  198, 0, 0};
    tbl[2]  = '{ 5, 12, SUB,    7, 1, 0};
    tbl[3]  = '{12,  5, SUB,    7, 0, 0};
    tbl[4]  = '{ 3,  3, SUB,    0, 0, 0};
    tbl[5]  = '{60, 40, MUL,    0, 2, 0};
    tbl[6]  = '{50, 40, MUL,    0, 2, 0};
    tbl[7]  = '{99, 20, MUL, 1980, 0, 0};
    tbl[8]  = '{10,  3, DVD,  333, 4, 14};
    tbl[9]  = '{99,  1, DVD,   99, 0, 14};
    tbl[10] = '{ 7,  0, DVD,   -1, 2, 0};
    tbl[11] = '{ 1,  4, DVD,   25, 4, 14};
    tbl[12] = '{39,  2, DVD, 1950, 4, 14};
    tbl[13] = '{41,  2, DVD,   20, 0, 14};
    tbl[14] = '{98, 49, DVD,    2, 0, 14};
    tbl[15] = '{ 0,  5, DVD,    0, 0, 14};

    Rst = 1'b1;
    bus.keys = 2'b00; bus.sw = 4'd0; bus.arifs = 4'b1111;
    repeat (2) @(negedge Clk);
    check("rst ind", int'(bus.ind_from_ALU), 0);
    check("rst code", int'(bus.c_from_ALU), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    Rst = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 16; i++) do_calc($sformatf("vec%0d", i), tbl[i], 1'b0);

    // Three digits, invalid digit and invalid op codes all leave A=12 in ENTER_A
    do_reset();
    press(2'b01, 1); press(2'b01, 2); press(2'b01, 3);
    check("three digits", int'(bus.ind_from_ALU), 12);
    press(2'b01, 11);
    check("digit 11 ignored", int'(bus.ind_from_ALU), 12);
    bus.arifs = 4'b1111; press(2'b10, 0);
    check("op 1111 stays", int'(bus.ind_from_ALU), 12);
    bus.arifs = 4'b1100; press(2'b10, 0);
    check("op 1100 stays", int'(bus.ind_from_ALU), 12);
    set_op(ADD);
    check("B cleared", int'(bus.ind_from_ALU), 0);
    enter_num(3); press(2'b10, 0);
    observe(1'b0, ind, code, busy_n, done_n);
    check("12+3 ind", ind, 15);

    // Simultaneous presses: keys[1] taken, digit discarded
    do_reset();
    enter_num(7);
    bus.arifs = ADD; press(2'b11, 5); bus.arifs = 4'b1111;
    check("both keys -> B", int'(bus.ind_from_ALU), 0);
    enter_num(4); press(2'b10, 0);
    observe(1'b0, ind, code, busy_n, done_n);
    check("7+4 ind", ind, 11);
    // Digit in DONE restarts with A=digit and one digit counted
    press(2'b01, 6);
    check("restart A", int'(bus.ind_from_ALU), 6);
    press(2'b01, 3);
    check("restart 2nd digit", int'(bus.ind_from_ALU), 63);
    set_op(ADD); enter_num(1); press(2'b10, 0);
    observe(1'b0, ind, code, busy_n, done_n);
    check("63+1 ind", ind, 64);
    press(2'b01, 12);
    check("DONE bad digit holds", int'(bus.ind_from_ALU), 64);
    press(2'b10, 0);
    check("DONE clear", int'(bus.ind_from_ALU), 0);

    // Presses during DIV are ignored
    do_calc("div poke", tbl[8], 1'b1);

    // A key held through reset registers as a press
    Rst = 1'b1; bus.sw = 4'd8; bus.keys = 2'b01;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    bus.keys = 2'b00;
    @(negedge Clk);
    check("held key at reset", int'(bus.ind_from_ALU), 8);

    // Reset in the middle of a division
    do_reset();
    enter_num(10); set_op(DVD); enter_num(3); press(2'b10, 0);
    cnt = 0;
    for (int i = 0; i < 30 && cnt < 7; i++) begin
      @(negedge Clk);
      cnt += int'(bus.busy);
    end
    check("div reached cycle 7", cnt, 7);
    #2 Rst = 1'b1;
    #1;
    check("mid-div rst ind", int'(bus.ind_from_ALU), 0);
    check("mid-div rst code", int'(bus.c_from_ALU), 0);
    check("mid-div rst busy", int'(bus.busy), 0);
    check("mid-div rst done", int'(bus.done), 0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    do_calc("after rst", tbl[0], 1'b0);

    for (int i = 0; i < 24; i++) begin
      v = model(int'($urandom_range(0, 99)), int'($urandom_range(0, 99)), ops[$urandom_range(0, 3)]);
      do_calc($sformatf("rnd%0d a=%0d b=%0d op=%b", i, v.a, v.b, v.op), v, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter: DISP_MAX, default 1999, largest magnitude the downstream 4-digit display accepts.
REQ-002 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Rst  input  1  reset, asynchronous and active-high.
REQ-004 sw  input  4  decimal digit from switches; values 10..15 are invalid digits.
REQ-005 keys  input  2  debounced pushbuttons, active-high; keys[0]=digit-enter, keys[1]=advance/execute.
REQ-006 arifs  input  4  operation buttons, active-low: 4'b1110 add, 4'b1101 sub, 4'b1011 mul, 4'b0111 div; 4'b1111 means no operation.
REQ-007 ind_from_ALU  output  11  unsigned magnitude for the display stage.
REQ-008 c_from_ALU  output  3  display code: 0 plain, 1 negative, 2 error, 4 two fractional digits (point after hundreds digit).
REQ-009 busy  output  1  high while a division is iterating.
REQ-010 done  output  1  one-cycle pulse when a result is first presented.

Function
REQ-011 Key presses SHALL be detected as rising edges of registered keys bits; held keys produce one press only.
REQ-012 States SHALL be ENTER_A, ENTER_B, EXEC, DIV, DONE.
REQ-013 Operands A and B SHALL be 7-bit, range 0..99, built from at most two digits.
REQ-014 In ENTER_A/ENTER_B, a keys[0] press with sw<=9 SHALL set operand = operand*10 + sw if the operand currently has fewer than 2 digits; otherwise the press is ignored.
REQ-015 A keys[0] press with sw>=10 SHALL be ignored.
REQ-016 In ENTER_A, a keys[1] press SHALL latch the operation only if arifs is exactly one of the four valid codes, clear B, and go to ENTER_B; otherwise stay in ENTER_A.
REQ-017 In ENTER_B, a keys[1] press SHALL go to EXEC.
REQ-018 Simultaneous keys[0] and keys[1] rising edges: keys[1] is taken, keys[0] is discarded.
REQ-019 During ENTER_A/ENTER_B, outputs SHALL show the operand being entered with code 0.
REQ-020 EXEC for add/sub/mul SHALL take one cycle, then DONE; EXEC for div SHALL go to DIV, or to DONE with code 2 if B==0.
REQ-021 Add: result A+B, code 0.
REQ-022 Sub: if A>=B, result A-B with code 0; else B-A with code 1.
REQ-023 Mul: if A*B<=DISP_MAX, result A*B with code 0; else result 0 with code 2.
REQ-024 Div SHALL use a restoring divider on dividend A*100 (14 bits) and divisor B, one quotient bit per cycle, 14 cycles in DIV, busy high throughout.
REQ-025 Div result: if A%B==0, A/B with code 0; else if Q=floor(A*100/B)<=DISP_MAX, Q with code 4; else floor(Q/100) with code 0.
REQ-026 Entering DONE SHALL assert done for exactly one cycle; outputs hold until the next press.
REQ-027 In DONE, keys[0] with a valid digit SHALL clear A, B, and the digit counts, set A=sw, and go to ENTER_A; keys[1] SHALL clear all and go to ENTER_A.
REQ-028 Key presses during EXEC/DIV SHALL be ignored.
REQ-029 arifs SHALL be sampled only at the keys[1] press in ENTER_A.

Reset
REQ-030 Rst high SHALL immediately force ENTER_A, A=B=0, digit counts 0, op none, ind_from_ALU=0, c_from_ALU=0, busy=0, done=0, divider registers 0, edge-detect registers 0, including mid-division.
REQ-031 After Rst deasserts, a key already held SHALL register as a press on its first sampled cycle.

Verification
REQ-032 Enter 4,2; add; enter 3,5; execute -> ind_from_ALU=77, c_from_ALU=0, one done pulse.
REQ-033 A=5, sub, B=12 -> ind_from_ALU=7, c_from_ALU=1; A=60, mul, B=40 -> ind_from_ALU=0, c_from_ALU=2.
REQ-034 A=10, div, B=3 -> busy high 14 cycles, then ind_from_ALU=333, c_from_ALU=4; A=99, div, B=1 -> ind_from_ALU=99, c_from_ALU=0; B=0 -> c_from_ALU=2 with no DIV cycles.
REQ-035 Three digits 1,2,3 into A -> A=12; sw=11 press ignored; keys[1] with arifs=4'b1111 or 4'b1100 -> remains in ENTER_A.
REQ-036 Assert Rst at DIV cycle 7 -> all outputs 0 asynchronously, state ENTER_A; a subsequent full add sequence completes correctly.
